// File: rtl/instr_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : instr_mem_ctrl
// Brief    : Single-port instruction memory with a one-entry ready/valid fetch
//            response stage and a program-load write port. Define
//            IMEM_PARITY_EN to store and check an even-parity bit per word.
// Revision : 1.0 - initial release
// ============================================================================
module instr_mem_ctrl #(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W+1:0] A,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] RD,
    output logic              rsp_err,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic [15:0]       fetch_cnt
);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [DATA_W-1:0]   r_rd;
    logic                r_err;
    logic [15:0]         r_fetch_cnt;

    logic                w_accept;
    logic                w_complete;
    logic [ADDR_W-1:0]   w_idx;
    logic [ADDR_W-1:0]   w_rd_idx;
    logic                w_in_range;
    logic                w_misalign;
    logic                w_ld_ok;
    logic [DATA_W-1:0]   w_mem_word;
    logic                w_par_err;

    assign w_idx      = A[ADDR_W+1:2];
    assign w_misalign = |A[1:0];
    assign w_in_range = 32'(w_idx) < 32'(DEPTH);
    // Clamp the read index so an out-of-range fetch never indexes past the array.
    assign w_rd_idx   = w_in_range ? w_idx : '0;
    assign w_mem_word = r_mem[w_rd_idx];
    assign w_ld_ok    = ld_en && (32'(ld_addr) < 32'(DEPTH));

    assign req_ready  = !reset && !ld_en && ((r_state == ST_EMPTY) || rsp_ready);
    assign w_accept   = req_valid && req_ready;
    assign w_complete = (r_state == ST_FULL) && rsp_ready;

    always_ff @(posedge clk) begin
        if (w_ld_ok) begin
            r_mem[ld_addr] <= ld_data;
        end
    end

`ifdef IMEM_PARITY_EN
    logic r_par [DEPTH];

    always_ff @(posedge clk) begin
        if (w_ld_ok) begin
            r_par[ld_addr] <= ^ld_data;
        end
    end

    assign w_par_err = (^w_mem_word) != r_par[w_rd_idx];
`else
    assign w_par_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_accept) w_state_nxt = ST_FULL;
            ST_FULL:  if (w_complete && !w_accept) w_state_nxt = ST_EMPTY;
            default:  w_state_nxt = ST_EMPTY;
        endcase
    end

    // Response data only changes on acceptance, so it holds through any stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd  <= '0;
            r_err <= 1'b0;
        end else if (w_accept) begin
            if (w_misalign || !w_in_range) begin
                r_rd  <= '0;
                r_err <= 1'b1;
            end else begin
                r_rd  <= w_mem_word;
                r_err <= w_par_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_cnt <= '0;
        end else if (w_complete && (r_fetch_cnt != c_CNT_MAX)) begin
            r_fetch_cnt <= r_fetch_cnt + 16'd1;
        end
    end

    assign rsp_valid = (r_state == ST_FULL);
    assign RD        = r_rd;
    assign rsp_err   = r_err;
    assign fetch_cnt = r_fetch_cnt;

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_mem_ctrl
// Brief    : Directed scenarios plus randomized traffic for instr_mem_ctrl,
//            checked against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_mem_ctrl;

    localparam int ADDR_W = 6;
    localparam int DEPTH  = 60;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W+1:0] A;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] RD;
    logic              rsp_err;
    logic              ld_en;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic [15:0]       fetch_cnt;

    instr_mem_ctrl #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .A         (A),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .RD        (RD),
        .rsp_err   (rsp_err),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .fetch_cnt (fetch_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: one pending response slot plus a word array.
    logic              m_valid = 1'b0;
    logic              m_err   = 1'b0;
    logic [DATA_W-1:0] m_rd    = '0;
    logic [15:0]       m_cnt   = '0;
    logic [DATA_W-1:0] m_mem [DEPTH];
    int                m_bad_par_idx = -1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input logic rst, input logic rv, input logic [7:0] a, input logic rr,
                        input logic le, input logic [5:0] la, input logic [31:0] ld);
        logic exp_ready;
        logic acc;
        logic cmp;
        int   idx;
        @(negedge clk);
        reset = rst; req_valid = rv; A = a; rsp_ready = rr;
        ld_en = le;  ld_addr = la;   ld_data = ld;
        #1;
        exp_ready = !rst && !le && (!m_valid || rr);
        check_val("req_ready", {31'd0, req_ready}, {31'd0, exp_ready});
        acc = rv && exp_ready;
        cmp = m_valid && rr;
        @(posedge clk);
        #1;
        if (rst) begin
            m_valid = 1'b0; m_rd = '0; m_err = 1'b0; m_cnt = '0;
        end else begin
            if (cmp && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            if (acc) begin
                idx = int'(a) / 4;
                if ((a % 4) != 0 || idx >= DEPTH) begin
                    m_rd = '0; m_err = 1'b1;
                end else begin
                    m_rd = m_mem[idx]; m_err = (idx == m_bad_par_idx);
                end
                m_valid = 1'b1;
            end else if (cmp) begin
                m_valid = 1'b0;
            end
        end
        if (le && int'(la) < DEPTH) begin
            m_mem[la] = ld;
            if (int'(la) == m_bad_par_idx) m_bad_par_idx = -1;
        end
        check_val("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_valid});
        check_val("fetch_cnt", {16'd0, fetch_cnt}, {16'd0, m_cnt});
        if (m_valid || rst) begin
            check_val("RD", RD, m_rd);
            check_val("rsp_err", {31'd0, rsp_err}, {31'd0, m_err});
        end
    endtask

    initial begin
        logic [7:0] a;
        reset = 1'b1; req_valid = 1'b0; A = '0; rsp_ready = 1'b0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;

        // Preload every address (including unimplemented ones) while in reset.
        for (int w = 0; w < 64; w++) step(1'b1, 1'b1, 8'd0, 1'b0, 1'b1, 6'(w), $urandom);
        step(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 6'd0, 32'd0);

        // Load then fetch word 0.
        step(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 6'd0, 32'h2002_0005);
        step(1'b0, 1'b1, 8'd0, 1'b1, 1'b0, 6'd0, 32'd0);
        step(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 6'd0, 32'd0);

        // Misaligned and out-of-range fetches.
        step(1'b0, 1'b1, 8'd2,   1'b1, 1'b0, 6'd0, 32'd0);
        step(1'b0, 1'b1, 8'd252, 1'b1, 1'b0, 6'd0, 32'd0);
        step(1'b0, 1'b0, 8'd0,   1'b1, 1'b0, 6'd0, 32'd0);

        // Stall three cycles, then back-to-back fetches.
        step(1'b0, 1'b1, 8'd4, 1'b0, 1'b0, 6'd0, 32'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'd8, 1'b0, 1'b0, 6'd0, 32'd0);
        step(1'b0, 1'b1, 8'd4,  1'b1, 1'b0, 6'd0, 32'd0);
        step(1'b0, 1'b1, 8'd8,  1'b1, 1'b0, 6'd0, 32'd0);
        step(1'b0, 1'b1, 8'd12, 1'b1, 1'b0, 6'd0, 32'd0);
        step(1'b0, 1'b0, 8'd0,  1'b1, 1'b0, 6'd0, 32'd0);

        // Load colliding with a request, then the request picks up the new word.
        step(1'b0, 1'b1, 8'd20, 1'b1, 1'b1, 6'd5, 32'hCAFE_F00D);
        step(1'b0, 1'b1, 8'd20, 1'b1, 1'b0, 6'd0, 32'd0);
        step(1'b0, 1'b0, 8'd0,  1'b1, 1'b0, 6'd0, 32'd0);

        // Load to a word whose response is held keeps the old data.
        step(1'b0, 1'b1, 8'd24, 1'b0, 1'b0, 6'd0, 32'd0);
        step(1'b0, 1'b0, 8'd0,  1'b0, 1'b1, 6'd6, 32'h1234_5678);
        step(1'b0, 1'b0, 8'd0,  1'b1, 1'b0, 6'd0, 32'd0);

        // Reset while a response is held; memory survives.
        step(1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 6'd0, 32'd0);
        step(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 6'd0, 32'd0);
        step(1'b0, 1'b1, 8'd0, 1'b1, 1'b0, 6'd0, 32'd0);
        step(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 6'd0, 32'd0);

`ifdef IMEM_PARITY_EN
        dut.r_par[1] = ~dut.r_par[1];
        m_bad_par_idx = 1;
        step(1'b0, 1'b1, 8'd4, 1'b1, 1'b0, 6'd0, 32'd0);
        step(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 6'd0, 32'd0);
`endif

        for (int i = 0; i < 600; i++) begin
            a = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            step(($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)), a,
                 ($urandom_range(0, 9) < 6), ($urandom_range(0, 5) == 0),
                 6'($urandom_range(0, 63)), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_mem_ctrl.md
INSTR_MEM_CTRL -- requirements
Module: instr_mem_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 6, meaning word-address width.
REQ-002 The block SHALL have parameter DEPTH, default 64, meaning implemented words, with DEPTH <= 2**ADDR_W.
REQ-003 The block SHALL have parameter DATA_W, default 32, meaning instruction width.
REQ-004 The block SHALL have port clk, input, 1, meaning the single clock, rising edge.
REQ-005 The block SHALL have port reset, input, 1, meaning reset, which is synchronous and active-high.
REQ-006 The block SHALL have port req_valid, input, 1, meaning a fetch request is present.
REQ-007 The block SHALL have port req_ready, output, 1, meaning a fetch request is accepted this cycle.
REQ-008 The block SHALL have port A, input, ADDR_W+2, meaning the byte address (PC).
REQ-009 The block SHALL have port rsp_valid, output, 1, meaning RD and rsp_err are valid.
REQ-010 The block SHALL have port rsp_ready, input, 1, meaning the consumer takes the response.
REQ-011 The block SHALL have port RD, output, DATA_W, meaning the fetched instruction.
REQ-012 The block SHALL have port rsp_err, output, 1, meaning a misaligned, out-of-range or parity fault.
REQ-013 The block SHALL have port ld_en, input, 1, meaning a program-load write strobe.
REQ-014 The block SHALL have port ld_addr, input, ADDR_W, meaning the load word address.
REQ-015 The block SHALL have port ld_data, input, DATA_W, meaning the load word.
REQ-016 The block SHALL have port fetch_cnt, output, 16, meaning the count of completed responses.

Function
REQ-017 The request SHALL be accepted when req_valid && req_ready, with req_ready = !ld_en && (!rsp_valid || rsp_ready).
REQ-018 The response SHALL appear exactly 1 cycle after acceptance: rsp_valid=1, RD=mem[A[ADDR_W+1:2]], rsp_err=0.
REQ-019 When A[1:0]!=0 at acceptance, the response SHALL be RD=0 and rsp_err=1.
REQ-020 When the word index is >= DEPTH at acceptance, the response SHALL be RD=0 and rsp_err=1.
REQ-021 While rsp_valid=1 && rsp_ready=0, RD, rsp_err and rsp_valid SHALL hold stable, with no new acceptance.
REQ-022 A response SHALL complete when rsp_valid && rsp_ready; rsp_valid SHALL then drop next cycle unless a new request is accepted in the same cycle (back-to-back, one response per cycle).
REQ-023 The state machine SHALL have EMPTY (rsp_valid=0) and FULL (rsp_valid=1) states.
REQ-024 State transitions SHALL be EMPTY->FULL on accept; FULL->EMPTY on completion without accept; FULL->FULL on stall or on completion with accept.
REQ-025 When ld_en=1, the block SHALL write mem[ld_addr]=ld_data at the clock edge; writes with ld_addr >= DEPTH SHALL be ignored.
REQ-026 ld_en SHALL have priority: no request is accepted in a cycle where ld_en=1.
REQ-027 A load to an address whose response is already registered SHALL leave the held RD unchanged (old data).
REQ-028 fetch_cnt SHALL increment by 1 per completed response, including errored ones, and SHALL saturate at 16'hFFFF.

Reset
REQ-029 On reset, the block SHALL set rsp_valid=0, RD=0, rsp_err=0, fetch_cnt=0 and state=EMPTY, discarding any held response.
REQ-030 While reset=1, req_ready SHALL be 0 and the block SHALL accept no request; a load with ld_en=1 during reset SHALL still be performed.
REQ-031 Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-032 With IMEM_PARITY_EN defined, each word SHALL store an even-parity bit computed at load; a fetch whose stored parity mismatches SHALL return RD=mem data with rsp_err=1.
REQ-033 Without IMEM_PARITY_EN, no parity storage SHALL exist, and rsp_err SHALL reflect only misalignment and range faults.

Verification
REQ-034 Scenario 1: load ld_addr=0, ld_data=32'h20020005, then request A=0 -> 1 cycle later rsp_valid=1, RD=32'h20020005, rsp_err=0.
REQ-035 Scenario 2: request A=6'd2 -> RD=0, rsp_err=1; request A=8'd252 with DEPTH=60 -> RD=0, rsp_err=1.
REQ-036 Scenario 3: rsp_ready=0 for 3 cycles after a response to A=4 -> RD stable, req_ready=0; then rsp_ready=1 with back-to-back requests A=4, 8, 12 -> one response per cycle, and fetch_cnt increments by 1 per completed response.
REQ-037 Scenario 4: ld_en=1 coincident with req_valid=1 -> req_ready=0; the request is accepted the next cycle and returns the newly loaded word.
REQ-038 Scenario 5: reset asserted while rsp_valid=1 -> next cycle rsp_valid=0, RD=0, fetch_cnt=0, and a prior load at word 0 still reads 32'h20020005.
REQ-039 Scenario 6 (IMEM_PARITY_EN): force a flipped stored bit at word 1, then request A=4 -> rsp_err=1.
